alu_issue_ctrl: RTL
===================

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 Parameter DONE_TIMEOUT, default 16: maximum cycles spent in WAIT before a multi-cycle ALU op is declared hung (legal range 2..255).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  an instruction is offered on in_instr.
REQ-005 in_instr  input  8  raw ISA instruction byte.
REQ-006 in_ready  output  1  controller accepts in_instr this cycle.
REQ-007 alu_valid  output  1  an ALU operation is offered on alu_opcode.
REQ-008 alu_opcode  output  4  decoded ALU opcode.
REQ-009 alu_ready  input  1  ALU takes the offered operation this cycle.
REQ-010 alu_done  input  1  ALU finished the current multi-cycle operation.
REQ-011 busy  output  1  controller is not in IDLE.
REQ-012 issue_cnt  output  16  count of operations handed to the ALU.
REQ-013 illegal_cnt  output  8  count of dropped illegal instructions.
REQ-014 timeout_err  output  1  sticky flag: a multi-cycle op never signalled done.

Function
REQ-015 Decode SHALL be evaluated in priority order:
- Exact byte: F6->5, F7->6, F8->7, F9->8, FA->9, FC->A, FE->B, FD->C.
- Otherwise, instr[7:4]=1110 -> 0.
- Otherwise, by instr[7:5]: 010->0, 011->1, 100->2, 101->3, 110->4.
REQ-016 The following are illegal and SHALL NOT be issued: instr[7:5] in {000, 001}, and bytes FB and FF.
REQ-017 Opcodes 0..4 are single-cycle; opcodes 5..C are multi-cycle.
REQ-018 FSM states are IDLE, ISSUE and WAIT; reset state is IDLE.
REQ-019 in_ready SHALL be 1 only in IDLE with reset low; an instruction is accepted when in_valid and in_ready are both 1.
REQ-020 IDLE, accept of a legal instruction: latch the decoded opcode into alu_opcode and go to ISSUE.
REQ-021 IDLE, accept of an illegal instruction: increment illegal_cnt (saturating at 255) and stay in IDLE.
REQ-022 ISSUE: alu_valid=1 and alu_opcode held stable until alu_ready=1.
REQ-023 ISSUE with alu_ready=1: increment issue_cnt (wrapping FFFF->0000); go to IDLE for single-cycle opcodes, or to WAIT for multi-cycle opcodes, with the wait counter cleared.
REQ-024 WAIT:
- alu_valid=0; the wait counter increments each cycle.
- alu_done=1: go to IDLE.
- Counter reaches DONE_TIMEOUT without done: set timeout_err, go to IDLE.
REQ-025 If alu_done=1 in the same cycle the counter reaches DONE_TIMEOUT, done SHALL win and timeout_err SHALL NOT be set.
REQ-026 alu_done outside WAIT SHALL be ignored.
REQ-027 alu_ready outside ISSUE SHALL be ignored.
REQ-028 Latency: accept in cycle N gives alu_valid=1 in cycle N+1. For a single-cycle op with alu_ready=1 in N+1, in_ready=1 again in N+2 (peak one instruction per two cycles).
REQ-029 busy = (state != IDLE).
REQ-030 alu_opcode SHALL hold its last value when alu_valid=0.
REQ-031 timeout_err SHALL clear only on reset.

Reset
REQ-032 When reset=1 at a clock edge: state becomes IDLE, and alu_opcode=0, issue_cnt=0, illegal_cnt=0, timeout_err=0, alu_valid=0, busy=0.
REQ-033 in_ready SHALL be 0 in any cycle where reset=1; nothing is accepted during reset.
REQ-034 Reset in ISSUE or WAIT SHALL abandon the operation without incrementing any counter; in_ready=1 in the first cycle after reset is released.

Verification
REQ-035 Accept F7, hold alu_ready=0 for 3 cycles then 1 -> alu_valid=1 with alu_opcode=6 for 4 cycles, issue_cnt=1, WAIT entered; alu_done after 2 cycles -> IDLE, timeout_err=0.
REQ-036 Stream E3, 45, 6A, 9F, B0, C1, each with alu_ready=1 -> opcodes 0, 0, 1, 2, 3, 4, one issue every 2 cycles, busy toggles, issue_cnt=6.
REQ-037 Offer 00, 3F, FB, FF -> all accepted, alu_valid never asserted, illegal_cnt=4; 300 illegal bytes -> illegal_cnt saturates at 255.
REQ-038 Accept FD (opcode C) with alu_done never asserted, DONE_TIMEOUT=16 -> timeout_err=1 after 16 WAIT cycles, back in IDLE; repeat with alu_done on the 16th cycle -> timeout_err stays 0.
REQ-039 Assert reset while in WAIT after issuing F8 -> next cycle all outputs at reset values, issue_cnt=0, in_ready=1 once reset is released; a stray alu_done in IDLE has no effect.
REQ-040 Force issue_cnt to FFFF, issue one single-cycle op -> issue_cnt=0000.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: decodes ISA bytes into ALU opcodes, hands them to the
// ALU with a valid/ready handshake and supervises multi-cycle completion.
module alu_issue_ctrl #(
   parameter int unsigned DONE_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   input  logic [7:0]  in_instr,
   output logic        in_ready,
   output logic        alu_valid,
   output logic [3:0]  alu_opcode,
   input  logic        alu_ready,
   input  logic        alu_done,
   output logic        busy,
   output logic [15:0] issue_cnt,
   output logic [7:0]  illegal_cnt,
   output logic        timeout_err
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } state_t;

   typedef struct packed {
      logic       legal;
      logic [3:0] opcode;
   } decode_t;

   localparam logic [7:0] TIMEOUT_C     = 8'(DONE_TIMEOUT);
   localparam logic [3:0] FIRST_MULTI_C = 4'd5;

   // Exact bytes take priority over the 1110xxxx group, which beats the [7:5] table.
   function automatic decode_t decode_instr(input logic [7:0] instr);
      decode_t res;
      res.legal  = 1'b1;
      res.opcode = 4'h0;
      case (instr)
         8'hF6:        res.opcode = 4'h5;
         8'hF7:        res.opcode = 4'h6;
         8'hF8:        res.opcode = 4'h7;
         8'hF9:        res.opcode = 4'h8;
         8'hFA:        res.opcode = 4'h9;
         8'hFC:        res.opcode = 4'hA;
         8'hFE:        res.opcode = 4'hB;
         8'hFD:        res.opcode = 4'hC;
         8'hFB, 8'hFF: res.legal  = 1'b0;
         default: begin
            if (instr[7:4] == 4'b1110) begin
               res.opcode = 4'h0;
            end else begin
               case (instr[7:5])
                  3'b010:  res.opcode = 4'h0;
                  3'b011:  res.opcode = 4'h1;
                  3'b100:  res.opcode = 4'h2;
                  3'b101:  res.opcode = 4'h3;
                  3'b110:  res.opcode = 4'h4;
                  default: res.legal  = 1'b0;
               endcase
            end
         end
      endcase
      return res;
   endfunction

   state_t      state_q, state_d;
   logic [3:0]  alu_opcode_q, alu_opcode_d;
   logic [15:0] issue_cnt_q, issue_cnt_d;
   logic [7:0]  illegal_cnt_q, illegal_cnt_d;
   logic        timeout_err_q, timeout_err_d;
   logic [7:0]  wait_cnt_q, wait_cnt_d;
   decode_t     dec_s;
   logic        accept_s;

   assign dec_s    = decode_instr(in_instr);
   assign in_ready = (state_q == ST_IDLE) && !reset;
   assign accept_s = in_valid && in_ready;

   // Next-state and datapath update for the issue FSM.
   always_comb begin
      state_d       = state_q;
      alu_opcode_d  = alu_opcode_q;
      issue_cnt_d   = issue_cnt_q;
      illegal_cnt_d = illegal_cnt_q;
      timeout_err_d = timeout_err_q;
      wait_cnt_d    = wait_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               if (dec_s.legal) begin
                  alu_opcode_d = dec_s.opcode;
                  state_d      = ST_ISSUE;
               end else if (illegal_cnt_q != 8'hFF) begin
                  illegal_cnt_d = illegal_cnt_q + 8'd1;
               end else begin
                  illegal_cnt_d = illegal_cnt_q;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            if (alu_ready) begin
               issue_cnt_d = issue_cnt_q + 16'd1;
               if (alu_opcode_q >= FIRST_MULTI_C) begin
                  state_d    = ST_WAIT;
                  wait_cnt_d = 8'd0;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               state_d = ST_ISSUE;
            end
         end
         ST_WAIT: begin
            wait_cnt_d = wait_cnt_q + 8'd1;
            // Done is checked first so a completion on the final cycle is not a timeout.
            if (alu_done) begin
               state_d = ST_IDLE;
            end else if ((wait_cnt_q + 8'd1) == TIMEOUT_C) begin
               timeout_err_d = 1'b1;
               state_d       = ST_IDLE;
            end else begin
               state_d = ST_WAIT;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and counter registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         alu_opcode_q  <= 4'h0;
         issue_cnt_q   <= 16'h0000;
         illegal_cnt_q <= 8'h00;
         timeout_err_q <= 1'b0;
         wait_cnt_q    <= 8'd0;
      end else begin
         state_q       <= state_d;
         alu_opcode_q  <= alu_opcode_d;
         issue_cnt_q   <= issue_cnt_d;
         illegal_cnt_q <= illegal_cnt_d;
         timeout_err_q <= timeout_err_d;
         wait_cnt_q    <= wait_cnt_d;
      end
   end

   assign alu_valid   = (state_q == ST_ISSUE);
   assign busy        = (state_q != ST_IDLE);
   assign alu_opcode  = alu_opcode_q;
   assign issue_cnt   = issue_cnt_q;
   assign illegal_cnt = illegal_cnt_q;
   assign timeout_err = timeout_err_q;

endmodule
